aura_mixer: RTL and testbench
=============================

# aura_mixer

Parametrised stereo audio mixer for the AURA FPGA. It replaces the fixed half-and-half VERA+OPM sum with NCH stereo sources, each with a CPU-programmable left/right volume. Samples are mixed by a time-multiplexed multiply-accumulate with saturation and sticky clip flags. It sits between the source decoders (I2S decoder, OPM) and the I2S encoder, and its registers are mapped on the I/O bus.

## Interface
- NCH, 2, number of stereo input channels, 1..8
- SW, 16, signed sample width (inputs and outputs)
- VOLW, 8, unsigned volume width; gain = vol / 2^(VOLW-1)
- ACCW, SW+VOLW+1+clog2(NCH), accumulator width (derived, not overridden)

Ports:
- clk  in  1  system clock (25 MHz)
- resetn  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle sample tick; begins a mix
- ch_left_i  in  NCH*SW  packed signed left samples; channel k occupies bits [k*SW +: SW]
- ch_right_i  in  NCH*SW  packed signed right samples
- reg_cs_n  in  1  register chip-select, active-low
- reg_wr_n  in  1  write strobe, active-low
- reg_a  in  5  register address
- reg_d  in  8  write data
- reg_q  out  8  read data, combinational from reg_a
- left_o  out  SW  mixed left sample
- right_o  out  SW  mixed right sample
- valid_o  out  1  one-cycle pulse when left_o/right_o update
- busy_o  out  1  high while a mix is in progress

## Operation
- Register map:
  - Address 2k: left volume of channel k.
  - Address 2k+1: right volume of channel k (k < NCH).
  - Address 16: control. Bit0 = mute. Bit1 = clip-clear, write-1 self-clearing, reads 0.
  - Address 17: status, read-only. Bit0 = left clip sticky, bit1 = right clip sticky, bit2 = busy_o.
  - Any other address: writes ignored, reads 0x00.
- Write commit:
  - A write commits on the first clk edge where reg_cs_n=0 and reg_wr_n=0 after an edge where either was high. This gives exactly one commit per strobe, however long the strobe lasts.
- FSM states: IDLE, MAC, SAT, OUT.
  - IDLE: on start_i=1, snapshot ch_left_i/ch_right_i into internal registers, clear both accumulators, set the channel counter to 0, go to MAC.
  - MAC: each cycle, acc_l += snap_l[k] * {0,vol_l[k]} and acc_r likewise (signed product). Use the volume register value current in that cycle. Increment k. After k=NCH-1, go to SAT.
  - SAT:
    - Arithmetically shift each accumulator right by VOLW-1.
    - If the result exceeds the SW signed range, clamp it to 2^(SW-1)-1 or -2^(SW-1), and set that side's clip sticky.
    - Go to OUT.
  - OUT: load left_o/right_o from the saturated results, or with 0 if mute=1. Pulse valid_o. Return to IDLE.
- Mute does not stop the computation. Under mute, clip stickies are not set.
- start_i outside IDLE is ignored and not queued.
- Clip-clear and a clip event on the same edge: set wins.
- Reset values:
  - left_o = right_o = 0, valid_o = 0, busy_o = 0.
  - All volumes = 2^(VOLW-2) (0x40, i.e. gain 0.5).
  - mute = 0, clip stickies = 0, FSM in IDLE.

## Timing
- start_i is sampled at edge T.
- MAC occupies edges T+1..T+NCH, SAT is at edge T+NCH+1, and outputs plus valid_o update at edge T+NCH+2.
- Latency is NCH+2 clocks.
- busy_o is high from T+1 through the OUT cycle inclusive. The earliest accepted next start_i is the cycle after valid_o.
- Maximum sample rate is clk/(NCH+3). For NCH=8 at 25 MHz this is far above 48.8 kHz.
- Outputs hold their values between valid_o pulses.
- Asserting resetn low mid-mix aborts immediately to reset values. No valid_o is produced for the aborted mix.
- reg_q follows reg_a combinationally. A register write is visible on reg_q the cycle after commit.

## Test plan
- Reset: assert resetn low asynchronously mid-MAC -> valid_o=0, busy_o=0, outputs 0; reading address 0 gives 0x40 and address 17 gives 0x00.
- Default mix, NCH=2: ch0 L=0x4000, ch1 L=0x2000, start_i -> valid_o at T+4 with left_o=0x3000.
- Unity and saturation: all volumes 0x80, both channels L=0x7000 -> left_o=0x7FFF and status bit0=1. Then write 0x02 to address 16 -> status bit0=0.
- Negative clamp: volume 0xFF on both channels, L=0x8000 -> left_o=0x8000 and clip set. Right channel at 0x0000 -> right_o=0, right clip clear.
- Mute and busy: write 0x01 to address 16, start_i -> valid_o pulses with outputs 0. A second start_i at T+2 is ignored: exactly one valid_o, and busy_o stays high for NCH+2 cycles.
- Write strobe: hold reg_cs_n=reg_wr_n=0 for 5 cycles at address 3 with data 0x10, changing reg_d to 0x20 after the first cycle -> register reads 0x10 (single commit). An address-20 write has no effect.

Source files
------------

// File: rtl/aura_mixer.sv
// aura_mixer: NCH-channel stereo mixer with per-channel programmable L/R volume.
// A single multiplier per side is time-shared over the channels (one channel per
// clock). The sum is then rescaled, saturated to SW bits, and presented on
// left_o/right_o.
//
// Handshake: start_i is a one-cycle tick that is accepted only while the FSM is
// IDLE (busy_o low). A tick that arrives while busy is dropped, not queued.
// valid_o is a one-cycle pulse with no backpressure. left_o/right_o hold their
// value until the next pulse.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   start_i                  sample tick, begins a mix
//   ch_left_i, ch_right_i    packed signed samples, channel k at [k*SW +: SW]
//   reg_cs_n, reg_wr_n       active-low register select / write strobe
//   reg_a, reg_d, reg_q      register address, write data, combinational read data
//   left_o, right_o          mixed, saturated output samples
//   valid_o                  one-cycle pulse when left_o/right_o update
//   busy_o                   high while a mix is in progress
module aura_mixer #(
  parameter int NCH  = 2,
  parameter int SW   = 16,
  parameter int VOLW = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [NCH*SW-1:0] ch_left_i,
  input  logic [NCH*SW-1:0] ch_right_i,
  input  logic              reg_cs_n,
  input  logic              reg_wr_n,
  input  logic [4:0]        reg_a,
  input  logic [7:0]        reg_d,
  output logic [7:0]        reg_q,
  output logic [SW-1:0]     left_o,
  output logic [SW-1:0]     right_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int ACCW = SW + VOLW + 1 + $clog2(NCH);
  localparam int PW   = SW + VOLW + 1;
  localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [VOLW-1:0] VOL_RST = VOLW'(1) << (VOLW - 2);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-SW+1){1'b1}}, {(SW-1){1'b0}}};
  localparam logic [SW-1:0] OUT_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0] OUT_MIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SAT, ST_OUT} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [SW-1:0]   snap_l_q [NCH];
  logic signed [SW-1:0]   snap_l_d [NCH];
  logic signed [SW-1:0]   snap_r_q [NCH];
  logic signed [SW-1:0]   snap_r_d [NCH];
  logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SW-1:0]          sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  logic [SW-1:0]          left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d;
  logic [VOLW-1:0]        vol_l_q [NCH];
  logic [VOLW-1:0]        vol_l_d [NCH];
  logic [VOLW-1:0]        vol_r_q [NCH];
  logic [VOLW-1:0]        vol_r_d [NCH];
  logic                   mute_q, mute_d;
  logic                   clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                   wr_prev_q, wr_prev_d;

  logic                   wr_act, commit;
  logic signed [PW-1:0]   prod_l, prod_r;
  logic signed [ACCW-1:0] sh_l, sh_r;
  logic                   over_l, under_l, over_r, under_r;
  logic [7:0]             rd_data;

  // A strobe commits only on its first active edge, so a long strobe writes once.
  assign wr_act    = !reg_cs_n && !reg_wr_n;
  assign commit    = wr_act && !wr_prev_q;
  assign wr_prev_d = wr_act;

  // Volume is zero-extended so the product stays a signed multiply.
  assign prod_l = PW'(snap_l_q[k_q]) * PW'($signed({1'b0, vol_l_q[k_q]}));
  assign prod_r = PW'(snap_r_q[k_q]) * PW'($signed({1'b0, vol_r_q[k_q]}));

  // Gain is vol/2^(VOLW-1), so the sum is rescaled with an arithmetic shift.
  assign sh_l    = acc_l_q >>> (VOLW - 1);
  assign sh_r    = acc_r_q >>> (VOLW - 1);
  assign over_l  = sh_l > SAT_MAX;
  assign under_l = sh_l < SAT_MIN;
  assign over_r  = sh_r > SAT_MAX;
  assign under_r = sh_r < SAT_MIN;

  // Register file next-state.
  always_comb begin
    vol_l_d  = vol_l_q;
    vol_r_d  = vol_r_q;
    mute_d   = mute_q;
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    if (commit) begin
      for (int k = 0; k < NCH; k++) begin
        if (reg_a == 5'(2 * k))     vol_l_d[k] = reg_d[VOLW-1:0];
        if (reg_a == 5'(2 * k + 1)) vol_r_d[k] = reg_d[VOLW-1:0];
      end
      if (reg_a == 5'd16) begin
        mute_d = reg_d[0];
        if (reg_d[1]) begin
          clip_l_d = 1'b0;
          clip_r_d = 1'b0;
        end
      end
    end
    // A clip event on the same edge as a clear wins.
    if (state_q == ST_SAT && !mute_q) begin
      if (over_l || under_l) clip_l_d = 1'b1;
      if (over_r || under_r) clip_r_d = 1'b1;
    end
  end

  // Mixer FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    sat_l_d  = sat_l_q;
    sat_r_d  = sat_r_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          for (int k = 0; k < NCH; k++) begin
            snap_l_d[k] = ch_left_i[k*SW +: SW];
            snap_r_d[k] = ch_right_i[k*SW +: SW];
          end
          acc_l_d = '0;
          acc_r_d = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_l_d = acc_l_q + ACCW'(prod_l);
        acc_r_d = acc_r_q + ACCW'(prod_r);
        if (k_q == KW'(NCH - 1)) begin
          state_d = ST_SAT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_SAT: begin
        if (over_l)       sat_l_d = OUT_MAX;
        else if (under_l) sat_l_d = OUT_MIN;
        else              sat_l_d = sh_l[SW-1:0];
        if (over_r)       sat_r_d = OUT_MAX;
        else if (under_r) sat_r_d = OUT_MIN;
        else              sat_r_d = sh_r[SW-1:0];
        state_d = ST_OUT;
      end
      ST_OUT: begin
        left_d  = mute_q ? '0 : sat_l_q;
        right_d = mute_q ? '0 : sat_r_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      sat_l_q   <= '0;
      sat_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      mute_q    <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      wr_prev_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        snap_l_q[k] <= '0;
        snap_r_q[k] <= '0;
        vol_l_q[k]  <= VOL_RST;
        vol_r_q[k]  <= VOL_RST;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      sat_l_q   <= sat_l_d;
      sat_r_q   <= sat_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      mute_q    <= mute_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      wr_prev_q <= wr_prev_d;
      snap_l_q  <= snap_l_d;
      snap_r_q  <= snap_r_d;
      vol_l_q   <= vol_l_d;
      vol_r_q   <= vol_r_d;
    end
  end

  // Combinational register read; clip-clear is a strobe and always reads 0.
  always_comb begin
    rd_data = 8'h00;
    if (reg_a == 5'd16) begin
      rd_data = {7'b0, mute_q};
    end else if (reg_a == 5'd17) begin
      rd_data = {5'b0, busy_o, clip_r_q, clip_l_q};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (reg_a == 5'(2 * k))     rd_data = 8'(vol_l_q[k]);
        if (reg_a == 5'(2 * k + 1)) rd_data = 8'(vol_r_q[k]);
      end
    end
  end

  assign reg_q   = rd_data;
  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aura_mixer.sv
module tb_aura_mixer;
  localparam int NCH  = 2;
  localparam int SW   = 16;
  localparam int VOLW = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start_i;
  logic [NCH*SW-1:0] ch_left_i, ch_right_i;
  logic              reg_cs_n, reg_wr_n;
  logic [4:0]        reg_a;
  logic [7:0]        reg_d;
  logic [7:0]        reg_q;
  logic [SW-1:0]     left_o, right_o;
  logic              valid_o, busy_o;

  aura_mixer #(.NCH(NCH), .SW(SW), .VOLW(VOLW)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i),
    .ch_left_i(ch_left_i), .ch_right_i(ch_right_i),
    .reg_cs_n(reg_cs_n), .reg_wr_n(reg_wr_n), .reg_a(reg_a), .reg_d(reg_d),
    .reg_q(reg_q), .left_o(left_o), .right_o(right_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int m_vol_l [NCH];
  int m_vol_r [NCH];
  bit m_mute, m_clip_l, m_clip_r;
  logic [2*SW-1:0] exp_q[$];

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_vol_l[k] = 64;
      m_vol_r[k] = 64;
    end
    m_mute = 0; m_clip_l = 0; m_clip_r = 0;
  endfunction

  function automatic void model_write(input int addr, input logic [7:0] data);
    if (addr < 2 * NCH) begin
      if (addr % 2 == 0) m_vol_l[addr/2] = data;
      else               m_vol_r[addr/2] = data;
    end else if (addr == 16) begin
      m_mute = data[0];
      if (data[1]) begin m_clip_l = 0; m_clip_r = 0; end
    end
  endfunction

  // Weighted sum with gain vol/128, floored, then clamped to 16-bit signed.
  function automatic longint mix_side(input logic [NCH*SW-1:0] smp, input bit left, output bit clip);
    longint s = 0;
    for (int k = 0; k < NCH; k++) begin
      logic signed [SW-1:0] v;
      v = smp[k*SW +: SW];
      s += longint'(v) * (left ? m_vol_l[k] : m_vol_r[k]);
    end
    s = s >>> 7;
    clip = 0;
    if (s > 32767)  begin s = 32767;  clip = 1; end
    if (s < -32768) begin s = -32768; clip = 1; end
    return s;
  endfunction

  function automatic void model_mix(input logic [NCH*SW-1:0] lv, input logic [NCH*SW-1:0] rv);
    bit cl, cr;
    longint el, er;
    el = mix_side(lv, 1, cl);
    er = mix_side(rv, 0, cr);
    if (m_mute) begin el = 0; er = 0; end
    else begin
      if (cl) m_clip_l = 1;
      if (cr) m_clip_r = 1;
    end
    exp_q.push_back({el[SW-1:0], er[SW-1:0]});
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input int addr, input logic [7:0] data);
    reg_a = 5'(addr); reg_d = data; reg_cs_n = 0; reg_wr_n = 0;
    tick();
    reg_cs_n = 1; reg_wr_n = 1;
    tick();
    model_write(addr, data);
  endtask

  task automatic reg_check(input string name, input int addr, input logic [7:0] exp);
    reg_a = 5'(addr);
    #1;
    check(name, reg_q, exp);
  endtask

  task automatic status_check(input string name);
    reg_check(name, 17, {5'b0, 1'b0, m_clip_r, m_clip_l});
  endtask

  task automatic run_mix(input string name, input logic [NCH*SW-1:0] lv, input logic [NCH*SW-1:0] rv);
    int n;
    logic [2*SW-1:0] e;
    model_mix(lv, rv);
    ch_left_i = lv; ch_right_i = rv; start_i = 1;
    tick();
    start_i = 0;
    n = 0;
    do begin tick(); n++; end while (!valid_o && n < 20);
    check({name, " latency"}, n, NCH + 2);
    e = exp_q.pop_front();
    if (valid_o) begin
      check({name, " left"}, left_o, e[2*SW-1:SW]);
      check({name, " right"}, right_o, e[SW-1:0]);
    end
    tick();
    check({name, " valid pulse width"}, valid_o, 0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0]        vl0, vl1, vr0, vr1;
    logic              mute;
    logic [NCH*SW-1:0] lv, rv;
    logic [SW-1:0]     el, er;
    logic              cl, cr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int vcnt, bcnt;

    vecs[0] = '{8'h40, 8'h40, 8'h40, 8'h40, 1'b0, {16'h2000, 16'h4000}, {16'h0000, 16'h0000}, 16'h3000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, {16'h7000, 16'h7000}, {16'hF000, 16'h1000}, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, {16'h8000, 16'h8000}, {16'h0000, 16'h0000}, 16'h8000, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h00, 8'h20, 8'h10, 1'b0, {16'h7FFF, 16'h1234}, {16'hFF00, 16'h0100}, 16'h1234, 16'h0020, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b1, {16'h7000, 16'h7000}, {16'h7000, 16'h7000}, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h00, 8'h01, 8'h00, 1'b0, {16'h0000, 16'hFFFF}, {16'h0000, 16'h0001}, 16'hFFFF, 16'h0000, 1'b0, 1'b0};

    resetn = 0; start_i = 0; ch_left_i = '0; ch_right_i = '0;
    reg_cs_n = 1; reg_wr_n = 1; reg_a = '0; reg_d = '0;
    model_reset();
    tick(); tick();
    resetn = 1;
    tick();

    // Reset state
    check("rst left_o", left_o, 0);
    check("rst right_o", right_o, 0);
    check("rst valid_o", valid_o, 0);
    check("rst busy_o", busy_o, 0);
    for (int a = 0; a < 2 * NCH; a++) reg_check("rst volume", a, 8'h40);
    reg_check("rst control", 16, 8'h00);
    reg_check("rst status", 17, 8'h00);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      reg_write(0, vecs[i].vl0);
      reg_write(2, vecs[i].vl1);
      reg_write(1, vecs[i].vr0);
      reg_write(3, vecs[i].vr1);
      reg_write(16, {6'b0, 1'b1, vecs[i].mute});
      run_mix($sformatf("vec%0d", i), vecs[i].lv, vecs[i].rv);
      check($sformatf("vec%0d table left", i), left_o, vecs[i].el);
      check($sformatf("vec%0d table right", i), right_o, vecs[i].er);
      reg_check($sformatf("vec%0d status", i), 17, {5'b0, 1'b0, vecs[i].cr, vecs[i].cl});
    end

    // Clip set then clear
    reg_write(16, 8'h02);
    reg_write(0, 8'h80); reg_write(2, 8'h80);
    run_mix("sat again", {16'h7000, 16'h7000}, '0);
    reg_check("clip set", 17, 8'h01);
    reg_write(16, 8'h02);
    reg_check("clip cleared", 17, 8'h00);
    reg_check("clip-clear reads 0", 16, 8'h00);

    // Mute: exactly one valid, second start ignored, busy for NCH+2 cycles
    reg_write(16, 8'h01);
    ch_left_i = {16'h7000, 16'h7000}; ch_right_i = {16'h1111, 16'h2222};
    start_i = 1;
    tick();
    start_i = 0;
    vcnt = valid_o; bcnt = busy_o;
    for (int i = 1; i < 16; i++) begin
      start_i = (i == 2);
      tick();
      start_i = 0;
      vcnt += valid_o;
      bcnt += busy_o;
    end
    check("mute valid count", vcnt, 1);
    check("mute busy cycles", bcnt, NCH + 2);
    check("mute left", left_o, 0);
    check("mute right", right_o, 0);
    reg_check("mute no clip", 17, 8'h00);
    reg_write(16, 8'h00);

    // Long write strobe commits once
    reg_a = 5'd3; reg_d = 8'h10; reg_cs_n = 0; reg_wr_n = 0;
    tick();
    reg_d = 8'h20;
    repeat (4) tick();
    reg_cs_n = 1; reg_wr_n = 1;
    tick();
    model_write(3, 8'h10);
    reg_check("strobe single commit", 3, 8'h10);
    reg_write(20, 8'h55);
    reg_check("addr 20 reads 0", 20, 8'h00);
    for (int a = 0; a < 2 * NCH; a++)
      reg_check("addr 20 no effect", a, 8'((a % 2 == 0) ? m_vol_l[a/2] : m_vol_r[a/2]));

    // Randomized mixes against the model
    for (int it = 0; it < 40; it++) begin
      logic [NCH*SW-1:0] lv, rv;
      for (int a = 0; a < 2 * NCH; a++) reg_write(a, 8'($urandom_range(0, 255)));
      reg_write(16, {6'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0)});
      for (int k = 0; k < NCH; k++) begin
        lv[k*SW +: SW] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        rv[k*SW +: SW] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      end
      run_mix($sformatf("rand%0d", it), lv, rv);
      status_check($sformatf("rand%0d status", it));
    end
    reg_write(16, 8'h02);

    // Asynchronous reset in the middle of MAC
    reg_write(0, 8'h80); reg_write(2, 8'h80);
    run_mix("pre-reset", {16'h0000, 16'h1000}, '0);
    check("pre-reset nonzero", left_o, 16'h1000);
    ch_left_i = {16'h0100, 16'h0100}; start_i = 1;
    tick();
    start_i = 0;
    tick();
    #5;
    resetn = 0;
    #1;
    model_reset();
    exp_q.delete();
    check("abort valid_o", valid_o, 0);
    check("abort busy_o", busy_o, 0);
    check("abort left_o", left_o, 0);
    check("abort right_o", right_o, 0);
    reg_check("abort vol0", 0, 8'h40);
    reg_check("abort status", 17, 8'h00);
    tick();
    #5;
    resetn = 1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vcnt += valid_o;
    end
    check("no valid after abort", vcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
